// File: rtl/posit_result_fifo.sv
// posit_result_fifo
//   First-word-fall-through result buffer behind a pipelined posit adder.
//   Each in_done pulse carries one {result, inf, zero} triple into the FIFO.
//   The head entry is shown combinationally on out_data/out_inf/out_zero.
//   stall throttles the feeder early enough that LAT results still in the
//   adder pipeline always find room.
//
// Parameters
//   N      posit word width
//   DEPTH  number of entries (power of two, >= 8)
//   LAT    upstream adder latency in cycles (LAT < DEPTH)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset (pointers, count, overflow)
//   in_result  adder result word, qualified by in_done
//   in_inf     adder inf flag, qualified by in_done
//   in_zero    adder zero flag, qualified by in_done
//   in_done    write strobe
//   stall      high when count >= DEPTH-LAT
//   out_data   head entry result
//   out_inf    head entry inf flag
//   out_zero   head entry zero flag
//   out_valid  head entry present (count != 0)
//   out_ready  consumer accepts the head this cycle
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: a write arrived while full with no pop
//
// Optional feature (macro POSIT_RESULT_STATS_EN)
//   inf_cnt    saturating count of accepted writes with inf=1
//   zero_cnt   saturating count of accepted writes with zero=1

module posit_result_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int LAT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             in_result,
  input  logic                     in_inf,
  input  logic                     in_zero,
  input  logic                     in_done,
  output logic                     stall,
  output logic [N-1:0]             out_data,
  output logic                     out_inf,
  output logic                     out_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
`ifdef POSIT_RESULT_STATS_EN
  output logic [15:0]              inf_cnt,
  output logic [15:0]              zero_cnt,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - LAT);

  // Storage: result word with its two flags packed alongside.
  logic [N+1:0]   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  assign full      = (count == FULL_LVL);
  assign out_valid = (count != '0);
  // out_ready is meaningless while empty, so pop cannot underflow.
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_en     = in_done & (~full | pop);
  assign drop      = in_done & full & ~pop;
  assign stall     = (count >= STALL_LVL);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Storage is not reset; a stray write during reset lands in a slot that
  // the cleared pointers already treat as empty.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {in_result, in_inf, in_zero};
  end

  // Fall-through read: head entry straight from the array, no output register.
  assign {out_data, out_inf, out_zero} = mem[rd_ptr];

`ifdef POSIT_RESULT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inf_cnt  <= '0;
      zero_cnt <= '0;
    end else begin
      if (wr_en && in_inf && (inf_cnt != 16'hFFFF))
        inf_cnt <= inf_cnt + 16'd1;
      if (wr_en && in_zero && (zero_cnt != 16'hFFFF))
        zero_cnt <= zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_result_fifo.sv
// Self-checking bench for posit_result_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.

module tb_posit_result_fifo;

  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           in_result;
  logic                   in_inf;
  logic                   in_zero;
  logic                   in_done;
  logic                   stall;
  logic [N-1:0]           out_data;
  logic                   out_inf;
  logic                   out_zero;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
`ifdef POSIT_RESULT_STATS_EN
  logic [15:0]            inf_cnt;
  logic [15:0]            zero_cnt;
`endif

  posit_result_fifo #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_result (in_result),
    .in_inf    (in_inf),
    .in_zero   (in_zero),
    .in_done   (in_done),
    .stall     (stall),
    .out_data  (out_data),
    .out_inf   (out_inf),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
`ifdef POSIT_RESULT_STATS_EN
    .inf_cnt   (inf_cnt),
    .zero_cnt  (zero_cnt),
`endif
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of {word, inf, zero} plus sticky flag.
  typedef struct {
    logic [N-1:0] word;
    logic         inf;
    logic         zero;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   m_inf;
  int   m_zero;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = q.size();
    check_val("out_valid", 64'(out_valid), 64'(sz != 0));
    check_val("count",     64'(count),     64'(sz));
    check_val("stall",     64'(stall),     64'(sz >= DEPTH - LAT));
    check_val("overflow",  64'(overflow),  64'(m_ovf));
    if (sz != 0) begin
      check_val("out_data", 64'(out_data), 64'(q[0].word));
      check_val("out_inf",  64'(out_inf),  64'(q[0].inf));
      check_val("out_zero", 64'(out_zero), 64'(q[0].zero));
    end
`ifdef POSIT_RESULT_STATS_EN
    check_val("inf_cnt",  64'(inf_cnt),  64'(m_inf));
    check_val("zero_cnt", 64'(zero_cnt), 64'(m_zero));
`endif
  endtask

  // One clock cycle: check current outputs, drive inputs, clock, update model.
  // Entered and left just after a falling edge.
  task automatic cycle(input bit d, input logic [N-1:0] w, input bit fi,
                       input bit fz, input bit rdy);
    bit   full;
    bit   do_pop;
    bit   accept;
    ent_t e;
    check_state();
    in_done   = d;
    in_result = w;
    in_inf    = fi;
    in_zero   = fz;
    out_ready = rdy;
    @(posedge clk);
    full   = (q.size() == DEPTH);
    do_pop = (q.size() != 0) && rdy;
    accept = d && (!full || do_pop);
    if (d && !accept) m_ovf = 1'b1;
    if (do_pop) begin
      e = q.pop_front();
      $display("pop  data=%08h inf=%0d zero=%0d", e.word, e.inf, e.zero);
    end
    if (accept) begin
      e.word = w; e.inf = fi; e.zero = fz;
      q.push_back(e);
      if (fi && m_inf  < 16'hFFFF) m_inf++;
      if (fz && m_zero < 16'hFFFF) m_zero++;
      $display("push data=%08h inf=%0d zero=%0d", w, fi, fz);
    end else if (d) begin
      $display("drop data=%08h", w);
    end
    @(negedge clk);
    in_done = 1'b0;
  endtask

  // Asynchronous reset between edges, with a write strobe held during it
  // that must be ignored.
  task automatic do_reset();
    #1;
    rst       = 1'b1;
    in_done   = 1'b1;
    in_result = $urandom;
    #1;
    check_val("rst_count",    64'(count),     64'd0);
    check_val("rst_valid",    64'(out_valid), 64'd0);
    check_val("rst_overflow", 64'(overflow),  64'd0);
    check_val("rst_stall",    64'(stall),     64'd0);
    q.delete();
    m_ovf  = 1'b0;
    m_inf  = 0;
    m_zero = 0;
    @(posedge clk);
    @(negedge clk);
    in_done = 1'b0;
    rst     = 1'b0;
    $display("reset");
  endtask

  initial begin
    rst       = 1'b1;
    in_done   = 1'b0;
    in_result = '0;
    in_inf    = 1'b0;
    in_zero   = 1'b0;
    out_ready = 1'b0;
    m_ovf     = 1'b0;
    m_inf     = 0;
    m_zero    = 0;
    #2;
    check_val("init_count",    64'(count),     64'd0);
    check_val("init_valid",    64'(out_valid), 64'd0);
    check_val("init_overflow", 64'(overflow),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single write becomes visible the following cycle.
    cycle(1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0);
    check_val("one_valid", 64'(out_valid), 64'd1);
    check_val("one_data",  64'(out_data),  64'h40000000);
    check_val("one_count", 64'(count),     64'd1);

    // Fill to DEPTH, then one more write is dropped.
    do_reset();
    for (int i = 1; i <= DEPTH; i++)
      cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    check_val("full_count", 64'(count),    64'd8);
    check_val("full_stall", 64'(stall),    64'd1);
    check_val("full_ovf",   64'(overflow), 64'd0);
    cycle(1'b1, 32'hDEAD0009, 1'b0, 1'b0, 1'b0);
    check_val("drop_ovf",   64'(overflow), 64'd1);
    check_val("drop_count", 64'(count),    64'd8);
    check_val("drop_head",  64'(out_data), 64'd1);

    // Write and pop together while full.
    do_reset();
    for (int i = 1; i <= DEPTH; i++)
      cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000099, 1'b1, 1'b0, 1'b1);
    check_val("wp_count", 64'(count),    64'd8);
    check_val("wp_head",  64'(out_data), 64'd2);
    check_val("wp_ovf",   64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++)
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_val("wp_tail",  64'(out_data), 64'h99);
    check_val("wp_tinf",  64'(out_inf),  64'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Streaming 1..5 with consumer always ready, then drain.
    do_reset();
    for (int i = 1; i <= 5; i++)
      cycle(1'b1, 32'(i), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_val("drain_count", 64'(count),     64'd0);
    check_val("drain_valid", 64'(out_valid), 64'd0);

    // Reset mid-stream with three entries held.
    do_reset();
    for (int i = 1; i <= 3; i++)
      cycle(1'b1, 32'(i * 7), 1'b0, 1'b0, 1'b0);
    check_val("pre_rst_count", 64'(count), 64'd3);
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

`ifdef POSIT_RESULT_STATS_EN
    // Flag counters: only accepted writes count.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFF, 1'b1, 1'b1, 1'b0);
    check_val("stat_inf",  64'(inf_cnt),  64'd3);
    check_val("stat_zero", 64'(zero_cnt), 64'd2);
`endif

    // Randomized traffic; write/read bias changes per phase so the FIFO
    // spends time empty, mid and full, and resets now and then.
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int wp;
      int rp;
      wp = $urandom_range(20, 90);
      rp = $urandom_range(10, 90);
      for (int c = 0; c < 80; c++) begin
        cycle(bit'($urandom_range(0, 99) < wp), $urandom,
              bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
              bit'($urandom_range(0, 99) < rp));
      end
      if (ph % 3 == 2) do_reset();
    end
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_result_fifo.md
POSIT_RESULT_FIFO -- requirements
Module: posit_result_fifo

Interface
REQ-001 SHALL have parameter N, default 32, posit word width.
REQ-002 SHALL have parameter DEPTH, default 8, entries; power of two, at least 8.
REQ-003 SHALL have parameter LAT, default 4, upstream posit_adder_4 latency in cycles; LAT < DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_result  input  N  adder result word.
REQ-007 SHALL have port in_inf  input  1  adder inf flag.
REQ-008 SHALL have port in_zero  input  1  adder zero flag.
REQ-009 SHALL have port in_done  input  1  adder done; qualifies in_result, in_inf and in_zero.
REQ-010 SHALL have port stall  output  1  upstream throttle; while high, the feeder keeps start low.
REQ-011 SHALL have port out_data  output  N  head entry result.
REQ-012 SHALL have port out_inf  output  1  head entry inf flag.
REQ-013 SHALL have port out_zero  output  1  head entry zero flag.
REQ-014 SHALL have port out_valid  output  1  head entry present.
REQ-015 SHALL have port out_ready  input  1  consumer accepts head.
REQ-016 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-017 SHALL have port overflow  output  1  sticky; a result was dropped.

Function
REQ-018 SHALL store {in_result, in_inf, in_zero} at the wr pointer on every rising edge with in_done=1 when not full.
REQ-019 SHALL be first-word-fall-through: out_valid = (count != 0); out_data/out_inf/out_zero driven from the head entry without a read-port register.
REQ-020 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-021 SHALL make a write on edge k visible as out_valid=1 in the cycle after edge k; there is no same-cycle bypass from in_done to out_valid.
REQ-022 SHALL, on simultaneous write and pop, leave count unchanged and advance both pointers; this applies when full as well.
REQ-023 SHALL, on write with count=DEPTH and no pop, drop the word, leave state unchanged and set overflow=1 until reset.
REQ-024 SHALL ignore out_ready while out_valid=0; count never underflows.
REQ-025 SHALL wrap pointers modulo DEPTH; count saturates at neither bound by arithmetic alone, only by REQ-023/REQ-024.
REQ-026 SHALL drive stall combinationally as (count >= DEPTH-LAT), so that LAT in-flight adder results never overflow.
REQ-027 SHALL pass in_inf and in_zero through unchanged with their word; they are not re-derived from in_result.

Reset
REQ-028 SHALL, while rst=1, asynchronously clear the rd/wr pointers, count and overflow; this gives out_valid=0 and stall=0.
REQ-029 SHALL leave storage contents unreset; out_data is don't-care while out_valid=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all stored entries; any in_done during rst=1 is ignored.

Configuration
REQ-031 SHALL, with macro POSIT_RESULT_STATS_EN defined, add outputs inf_cnt[15:0] and zero_cnt[15:0].
REQ-032 With POSIT_RESULT_STATS_EN, inf_cnt and zero_cnt SHALL count accepted writes whose inf/zero flag is 1, SHALL saturate at 0xFFFF and SHALL be cleared by rst.
REQ-033 SHALL, without POSIT_RESULT_STATS_EN, omit these ports and counters; all other behaviour is identical.

Verification
REQ-034 Reset, then one write 0x40000000 with out_ready=0 -> next cycle out_valid=1, out_data=0x40000000, count=1.
REQ-035 8 consecutive writes with out_ready=0 (DEPTH=8) -> stall=1 from count=4, count=8, overflow=0; a 9th write -> overflow=1, count stays 8, head unchanged.
REQ-036 Full FIFO, in_done=1 and out_ready=1 together -> count stays 8, head advances, new word appears at tail, overflow=0.
REQ-037 Write words 1..5, out_ready held 1 -> output order 1..5, count returns to 0, out_valid=0.
REQ-038 rst pulse mid-stream with count=3 -> count=0, out_valid=0 and overflow=0 immediately, without waiting for clk.
REQ-039 With POSIT_RESULT_STATS_EN: 3 writes with in_inf=1, 2 with in_zero=1 -> inf_cnt=3, zero_cnt=2; dropped writes are not counted.
